// File: rtl/ovrd_pkg.sv
// Shared constants and types for the overdrive output stage.
// Sample-width-dependent patterns are rebuilt per instance from fxp_size.
package ovrd_pkg;
   localparam int FXP_SIZE_DEF       = 16;
   localparam int HOLD_CYCLES_DEF    = 4800000;
   localparam int WINDOW_SAMPLES_DEF = 48000;
   localparam int CNT_W_DEF          = 16;

   localparam logic [FXP_SIZE_DEF-1:0] SAT_MAX_DEF = {1'b0, {(FXP_SIZE_DEF-1){1'b1}}};
   localparam logic [FXP_SIZE_DEF-1:0] SAT_MIN_DEF = {1'b1, {(FXP_SIZE_DEF-1){1'b0}}};

   typedef logic [CNT_W_DEF-1:0] clip_cnt_t;
endpackage

// File: rtl/ovrd_output_saturator_if.sv
// Sample handshake between the overdrive stage, this saturator and the codec path.
interface ovrd_output_saturator_if
   import ovrd_pkg::*;
   #(parameter int fxp_size = FXP_SIZE_DEF) ();
   logic [2*fxp_size-1:0] i_sample;
   logic                  i_overflow;
   logic                  i_valid;
   logic                  o_ready;
   logic [fxp_size-1:0]   o_sample;
   logic                  o_valid;
   logic                  i_ready;

   modport master (output i_sample, i_overflow, i_valid, i_ready,
                   input  o_ready, o_sample, o_valid);
   modport slave  (input  i_sample, i_overflow, i_valid, i_ready,
                   output o_ready, o_sample, o_valid);
endinterface

// File: rtl/sat_skid_fifo.sv
// Two-entry skid FIFO; in_ready is registered so it never depends on out_ready combinationally.
module sat_skid_fifo #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] mem [2];
   logic         wr_ptr, rd_ptr;
   logic [1:0]   cnt, cnt_nxt;
   logic         push, pop;

   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_valid = (cnt != 2'd0);
   assign out_data  = mem[rd_ptr];

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop)      cnt_nxt = cnt + 2'd1;
      else if (!push && pop) cnt_nxt = cnt - 2'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         cnt      <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt      <= cnt_nxt;
         in_ready <= (cnt_nxt != 2'd2);
      end
   end
endmodule

// File: rtl/ovrd_output_saturator.sv
// Narrows the overdrive result to fxp_size with saturation, buffers it through a skid FIFO,
// and tracks clipping for a held LED and a per-window clip count.
module ovrd_output_saturator
   import ovrd_pkg::*;
   #(
   parameter int fxp_size       = FXP_SIZE_DEF,
   parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
   parameter int WINDOW_SAMPLES = WINDOW_SAMPLES_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   ovrd_output_saturator_if.slave  bus,
   input  logic                    i_clear,
   output logic                    o_clip_led,
   output logic [CNT_W-1:0]        o_clip_count,
   output logic                    o_count_strobe
);
   localparam logic [fxp_size-1:0] SAT_MAX = {1'b0, {(fxp_size-1){1'b1}}};
   localparam logic [fxp_size-1:0] SAT_MIN = {1'b1, {(fxp_size-1){1'b0}}};
   localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
   localparam int WIN_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;

   logic [fxp_size:0]   hi;
   logic                fits, accept, clip;
   logic [fxp_size-1:0] sat;

   // The top fxp_size+1 bits must all match the sign for the value to be representable.
   assign hi     = bus.i_sample[2*fxp_size-1:fxp_size-1];
   assign fits   = (&hi) | (~|hi);
   assign sat    = fits ? bus.i_sample[fxp_size-1:0]
                        : (bus.i_sample[2*fxp_size-1] ? SAT_MIN : SAT_MAX);
   assign accept = bus.i_valid & bus.o_ready;
   assign clip   = accept & (bus.i_overflow | ~fits);

   sat_skid_fifo #(.W(fxp_size)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_data   (sat),
      .in_valid  (bus.i_valid),
      .in_ready  (bus.o_ready),
      .out_data  (bus.o_sample),
      .out_valid (bus.o_valid),
      .out_ready (bus.i_ready)
   );

   logic [TMR_W-1:0] tmr;

   assign o_clip_led = (tmr != '0);

   // A clip in the same cycle as a clear keeps the LED lit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             tmr <= '0;
      else if (clip)        tmr <= TMR_W'(HOLD_CYCLES);
      else if (i_clear)     tmr <= '0;
      else if (tmr != '0)   tmr <= tmr - TMR_W'(1);
   end

   logic [WIN_W-1:0] win;
   logic [CNT_W-1:0] run, run_inc;
   logic             win_last;

   assign run_inc  = (clip && (run != '1)) ? run + CNT_W'(1) : run;
   assign win_last = (win == WIN_W'(WINDOW_SAMPLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win            <= '0;
         run            <= '0;
         o_clip_count   <= '0;
         o_count_strobe <= 1'b0;
      end else begin
         o_count_strobe <= 1'b0;
         if (i_clear) begin
            win          <= '0;
            run          <= '0;
            o_clip_count <= '0;
         end else if (accept) begin
            if (win_last) begin
               o_clip_count   <= run_inc;
               run            <= '0;
               win            <= '0;
               o_count_strobe <= 1'b1;
            end else begin
               run <= run_inc;
               win <= win + WIN_W'(1);
            end
         end
      end
   end
endmodule
